// File: rtl/bus_cycle_gen_if.sv
// Request/response and system-bus signal bundle for the bus cycle initiator.
// master: the initiator itself. slave: whoever issues requests and models the bus.
interface bus_cycle_gen_if;
  logic        req;
  logic        req_we;
  logic        req_iom;
  logic        req_inta;
  logic [19:0] req_addr;
  logic [7:0]  req_wdata;
  logic        ack;
  logic        err;
  logic [7:0]  rdata;
  logic        busy;
  logic [19:0] bus_addr;
  logic        bus_iom;
  logic        bus_rd_n;
  logic        bus_wr_n;
  logic        bus_inta_n;
  logic [7:0]  bus_dout;
  logic [7:0]  bus_din;
  logic        bus_ready;

  modport master (
    input  req, req_we, req_iom, req_inta, req_addr, req_wdata, bus_din, bus_ready,
    output ack, err, rdata, busy, bus_addr, bus_iom, bus_rd_n, bus_wr_n, bus_inta_n, bus_dout
  );

  modport slave (
    output req, req_we, req_iom, req_inta, req_addr, req_wdata, bus_din, bus_ready,
    input  ack, err, rdata, busy, bus_addr, bus_iom, bus_rd_n, bus_wr_n, bus_inta_n, bus_dout
  );
endinterface

// File: rtl/bus_cycle_gen.sv
// 8088-style bus cycle initiator: turns one request into a T1..T4 cycle with
// forced and ready-driven wait states, timeout abort and the two-pulse INTA
// sequence. Every output is a register loaded from the next-state logic, so
// the value seen during a state was decided on the edge that entered it.
module bus_cycle_gen #(
  parameter int unsigned WAIT_STATES = 0,
  parameter int unsigned TIMEOUT     = 255
) (
  input logic             clk,
  input logic             rst_n,
  bus_cycle_gen_if.master bif
);

  localparam logic [3:0] WAIT_INIT = WAIT_STATES[3:0];
  localparam logic [7:0] TMO_LIMIT = TIMEOUT[7:0];

  typedef enum logic [2:0] {S_IDLE, S_T1, S_T2, S_T3, S_T4} state_t;

  state_t      state_q, state_d;
  logic        we_q, we_d;
  logic        inta_q, inta_d;
  logic        phase_q, phase_d;    // 1 while running the second INTA pulse
  logic [3:0]  wait_q, wait_d;
  logic [7:0]  tmo_q, tmo_d, tmo_inc;
  logic        ack_q, ack_d;
  logic        err_q, err_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        busy_q, busy_d;
  logic [19:0] addr_q, addr_d;      // doubles as the address latch
  logic        iom_q, iom_d;
  logic [7:0]  dout_q, dout_d;
  logic        rd_n_q, rd_n_d;
  logic        wr_n_q, wr_n_d;
  logic        inta_n_q, inta_n_d;
  logic        strobe_on;
  logic        done;

  // Next-state and next-output decode for the bus cycle sequencer
  always_comb begin
    state_d   = state_q;
    we_d      = we_q;
    inta_d    = inta_q;
    phase_d   = phase_q;
    wait_d    = wait_q;
    tmo_d     = tmo_q;
    tmo_inc   = tmo_q + 8'd1;
    ack_d     = 1'b0;
    err_d     = 1'b0;
    rdata_d   = rdata_q;
    addr_d    = addr_q;
    iom_d     = iom_q;
    dout_d    = dout_q;
    done      = (wait_q == 4'd0) && bif.bus_ready;

    case (state_q)
      S_IDLE: begin
        if (bif.req) begin
          // INTA overrides the direction and space selects
          state_d = S_T1;
          we_d    = bif.req_we & ~bif.req_inta;
          inta_d  = bif.req_inta;
          phase_d = 1'b0;
          addr_d  = bif.req_inta ? 20'h00000 : bif.req_addr;
          iom_d   = bif.req_inta | bif.req_iom;
          dout_d  = (bif.req_we & ~bif.req_inta) ? bif.req_wdata : 8'h00;
        end
      end
      S_T1: begin
        wait_d  = WAIT_INIT;
        tmo_d   = 8'd0;
        state_d = S_T2;
      end
      S_T2: begin
        state_d = S_T3;
      end
      S_T3: begin
        tmo_d = tmo_inc;
        if (done) begin
          state_d = S_T4;
          // The first INTA pulse completes silently and its data is dropped
          if (!inta_q || phase_q) begin
            ack_d = 1'b1;
            if (!we_q) begin
              rdata_d = bif.bus_din;
            end
          end
        end else begin
          if (wait_q != 4'd0) begin
            wait_d = wait_q - 4'd1;
          end
          // Completion wins over abort when both land on the last cycle
          if (tmo_inc == TMO_LIMIT) begin
            state_d = S_T4;
            ack_d   = 1'b1;
            err_d   = 1'b1;
            rdata_d = 8'hFF;
          end
        end
      end
      S_T4: begin
        // ack is already showing if this was the final cycle of the request
        if (ack_q) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_T1;
          phase_d = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Strobes are low during T2 and T3/TW of the state being entered
    strobe_on = (state_d == S_T2) || (state_d == S_T3);
    rd_n_d    = ~(strobe_on & ~we_q & ~inta_q);
    wr_n_d    = ~(strobe_on & we_q);
    inta_n_d  = ~(strobe_on & inta_q);
    busy_d    = (state_d != S_IDLE);
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      we_q     <= 1'b0;
      inta_q   <= 1'b0;
      phase_q  <= 1'b0;
      wait_q   <= 4'd0;
      tmo_q    <= 8'd0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= 8'h00;
      busy_q   <= 1'b0;
      addr_q   <= 20'h00000;
      iom_q    <= 1'b0;
      dout_q   <= 8'h00;
      rd_n_q   <= 1'b1;
      wr_n_q   <= 1'b1;
      inta_n_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      inta_q   <= inta_d;
      phase_q  <= phase_d;
      wait_q   <= wait_d;
      tmo_q    <= tmo_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
      busy_q   <= busy_d;
      addr_q   <= addr_d;
      iom_q    <= iom_d;
      dout_q   <= dout_d;
      rd_n_q   <= rd_n_d;
      wr_n_q   <= wr_n_d;
      inta_n_q <= inta_n_d;
    end
  end

  assign bif.ack        = ack_q;
  assign bif.err        = err_q;
  assign bif.rdata      = rdata_q;
  assign bif.busy       = busy_q;
  assign bif.bus_addr   = addr_q;
  assign bif.bus_iom    = iom_q;
  assign bif.bus_dout   = dout_q;
  assign bif.bus_rd_n   = rd_n_q;
  assign bif.bus_wr_n   = wr_n_q;
  assign bif.bus_inta_n = inta_n_q;

endmodule

// File: tb/tb_bus_cycle_gen.sv
// Bench for bus_cycle_gen: three instances with different wait/timeout
// settings share one stimulus set; only the selected one sees req. A
// responder inside do_txn plays the bus target, and expectations come from
// a cycle-count model of the bus protocol.
module tb_bus_cycle_gen;

  localparam int NI = 3;
  localparam int WS_T [NI] = '{0, 0, 2};
  localparam int TO_T [NI] = '{255, 4, 8};

  logic        clk;
  logic        rst_n;
  int          sel;
  logic        req, req_we, req_iom, req_inta;
  logic [19:0] req_addr;
  logic [7:0]  req_wdata, bus_din;
  logic        bus_ready;

  logic        ack_v [NI], err_v [NI], busy_v [NI], iom_v [NI];
  logic        rd_n_v [NI], wr_n_v [NI], inta_n_v [NI];
  logic [7:0]  rdata_v [NI], dout_v [NI];
  logic [19:0] addr_v [NI];

  int          n_checks, n_err;
  logic [7:0]  exp_rd [NI];

  // results gathered by do_txn
  int          m_ack_at [4];
  logic        m_err [4];
  logic [7:0]  m_rdata [4];
  int          m_nack, m_rd_lo, m_wr_lo, m_inta_lo, m_pulses, m_min_gap;
  int          m_overlap, m_unstable;
  int          m_runs [$];
  logic        m_post_busy, m_post_ack, m_busy_after;
  logic [2:0]  m_post_strobes;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar gi = 0; gi < NI; gi++) begin : g
    bus_cycle_gen_if bif ();
    assign bif.req       = (sel == gi) ? req : 1'b0;
    assign bif.req_we    = req_we;
    assign bif.req_iom   = req_iom;
    assign bif.req_inta  = req_inta;
    assign bif.req_addr  = req_addr;
    assign bif.req_wdata = req_wdata;
    assign bif.bus_din   = bus_din;
    assign bif.bus_ready = bus_ready;
    bus_cycle_gen #(.WAIT_STATES(WS_T[gi]), .TIMEOUT(TO_T[gi])) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bif   (bif)
    );
    assign ack_v[gi]    = bif.ack;
    assign err_v[gi]    = bif.err;
    assign rdata_v[gi]  = bif.rdata;
    assign busy_v[gi]   = bif.busy;
    assign addr_v[gi]   = bif.bus_addr;
    assign iom_v[gi]    = bif.bus_iom;
    assign rd_n_v[gi]   = bif.bus_rd_n;
    assign wr_n_v[gi]   = bif.bus_wr_n;
    assign inta_n_v[gi] = bif.bus_inta_n;
    assign dout_v[gi]   = bif.bus_dout;
  end

  // Model: T3/TW cycles needed. Forced waits and not-ready cycles overlap;
  // the cycle completes at T3 index max(ws, rd) if that is below the limit.
  function automatic bit completes(int ws, int to, int rd);
    int need;
    need = (ws > rd) ? ws : rd;
    return need <= to - 1;
  endfunction

  function automatic int t3_len(int ws, int to, int rd);
    int need;
    need = (ws > rd) ? ws : rd;
    return (need <= to - 1) ? need + 1 : to;
  endfunction

  // Issue one request on instance s and act as the bus target. The target
  // holds bus_ready low for the first rd cycles of T3/TW; bus_din carries
  // din0 during the first strobe pulse and din1 during later ones.
  task automatic do_txn(input int s, input logic we, input logic iom, input logic inta,
                        input logic [19:0] addr, input logic [7:0] wd, input int rd,
                        input logic [7:0] din0, input logic [7:0] din1, input bit hold,
                        input int n_acks, input int rst_at);
    logic [19:0] e_addr;
    logic        e_iom;
    logic [7:0]  e_dout;
    logic        rdn, wrn, intn, stb;
    int          run, hi, last_ack;
    e_addr = inta ? 20'h00000 : addr;
    e_iom  = inta | iom;
    e_dout = (we & ~inta) ? wd : 8'h00;
    m_nack = 0; m_rd_lo = 0; m_wr_lo = 0; m_inta_lo = 0; m_pulses = 0;
    m_min_gap = 999; m_overlap = 0; m_unstable = 0; m_runs.delete();
    m_post_busy = 1'bx; m_post_ack = 1'bx; m_post_strobes = 3'bxxx; m_busy_after = 1'bx;
    run = 0; hi = 0; last_ack = -10;
    @(negedge clk);
    sel = s; req = 1'b1; req_we = we; req_iom = iom; req_inta = inta;
    req_addr = addr; req_wdata = wd;
    bus_ready = 1'($urandom); bus_din = 8'($urandom);
    @(posedge clk);
    for (int k = 1; k <= 400; k++) begin
      @(negedge clk);
      if (k == 1 && !hold) begin
        req = 1'b0; req_we = 1'($urandom); req_iom = 1'($urandom);
        req_inta = 1'($urandom); req_addr = 20'($urandom); req_wdata = 8'($urandom);
      end
      rdn = rd_n_v[s]; wrn = wr_n_v[s]; intn = inta_n_v[s];
      stb = !rdn || !wrn || !intn;
      if (int'(!rdn) + int'(!wrn) + int'(!intn) > 1) m_overlap++;
      if (!rdn) m_rd_lo++;
      if (!wrn) m_wr_lo++;
      if (!intn) m_inta_lo++;
      if (stb) begin
        run++;
        if (run == 1) begin
          if (m_pulses > 0 && hi < m_min_gap) m_min_gap = hi;
          m_pulses++;
        end
        hi = 0;
      end else begin
        if (run > 0) m_runs.push_back(run);
        run = 0;
        hi++;
      end
      if (busy_v[s] && (addr_v[s] !== e_addr || iom_v[s] !== e_iom || dout_v[s] !== e_dout))
        m_unstable++;
      if (k == last_ack + 1) m_busy_after = busy_v[s];
      if (ack_v[s]) begin
        if (m_nack < 4) begin
          m_ack_at[m_nack] = k; m_err[m_nack] = err_v[s]; m_rdata[m_nack] = rdata_v[s];
        end
        m_nack++;
        last_ack = k;
      end
      // target response for the coming edge
      if (stb && run >= 2) bus_ready = ((run - 2) >= rd);
      else bus_ready = 1'($urandom);
      if (stb) bus_din = (m_pulses <= 1) ? din0 : din1;
      else bus_din = 8'($urandom);
      if (hold && last_ack > 0 && m_nack >= n_acks - 1 && k > last_ack + 1) req = 1'b0;
      if (rst_at > 0 && k == rst_at) rst_n = 1'b0;
      if (rst_at > 0 && k == rst_at + 1) begin
        m_post_busy = busy_v[s]; m_post_ack = ack_v[s];
        m_post_strobes = {rdn, wrn, intn}; rst_n = 1'b1;
      end
      if (n_acks > 0 && m_nack >= n_acks && k >= last_ack + 3) break;
      if (rst_at > 0 && k >= rst_at + 4) break;
      if (k == 400) $display("FAIL txn_bound: no completion within 400 cycles on inst %0d", s);
    end
    req = 1'b0;
  endtask

  task automatic test_reset();
    logic [42:0] e_rst, got;
    rst_n = 1'b0; sel = 0; req = 1'b0; req_we = 1'b0; req_iom = 1'b0; req_inta = 1'b0;
    req_addr = 20'h0; req_wdata = 8'h0; bus_din = 8'h0; bus_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    e_rst = {1'b0, 1'b0, 8'h00, 1'b0, 20'h00000, 1'b0, 3'b111, 8'h00};
    for (int i = 0; i < NI; i++) begin
      got = {ack_v[i], err_v[i], rdata_v[i], busy_v[i], addr_v[i], iom_v[i],
             rd_n_v[i], wr_n_v[i], inta_n_v[i], dout_v[i]};
      n_checks++;
      if (got !== e_rst) begin
        n_err++; $display("FAIL reset_outputs inst %0d: got %h expected %h", i, got, e_rst);
      end
      exp_rd[i] = 8'h00;
    end
    rst_n = 1'b1;
    $display("txn reset: outputs checked on %0d instances", NI);
  endtask

  task automatic test_mem_read();
    do_txn(0, 1'b0, 1'b0, 1'b0, 20'hFC010, 8'h00, 0, 8'hA5, 8'h5A, 1'b0, 1, 0);
    $display("txn mem_read: ack_at=%0d rdata=%h err=%b rd_lo=%0d", m_ack_at[0], m_rdata[0], m_err[0], m_rd_lo);
    n_checks++; if (m_nack !== 1) begin n_err++; $display("FAIL rd_ack_count: got %0d expected 1", m_nack); end
    n_checks++; if (m_ack_at[0] !== 4) begin n_err++; $display("FAIL rd_ack_cycle: got %0d expected 4", m_ack_at[0]); end
    n_checks++; if (m_rdata[0] !== 8'hA5 || m_err[0] !== 1'b0) begin
      n_err++; $display("FAIL rd_data: got %h/%b expected a5/0", m_rdata[0], m_err[0]); end
    n_checks++; if (m_rd_lo !== 2 || m_wr_lo !== 0 || m_inta_lo !== 0) begin
      n_err++; $display("FAIL rd_strobes: got %0d/%0d/%0d expected 2/0/0", m_rd_lo, m_wr_lo, m_inta_lo); end
    n_checks++; if (m_unstable !== 0) begin n_err++; $display("FAIL rd_addr_iom: got %0d bad cycles expected 0", m_unstable); end
    n_checks++; if (m_busy_after !== 1'b0) begin n_err++; $display("FAIL rd_busy_after: got %b expected 0", m_busy_after); end
    exp_rd[0] = 8'hA5;
  endtask

  task automatic test_io_write();
    do_txn(0, 1'b1, 1'b1, 1'b0, 20'h00056, 8'h3C, 3, 8'h77, 8'h77, 1'b0, 1, 0);
    $display("txn io_write: ack_at=%0d wr_lo=%0d rdata=%h", m_ack_at[0], m_wr_lo, m_rdata[0]);
    n_checks++; if (m_wr_lo !== 5 || m_rd_lo !== 0 || m_inta_lo !== 0) begin
      n_err++; $display("FAIL wr_strobes: got %0d/%0d/%0d expected 0/5/0", m_rd_lo, m_wr_lo, m_inta_lo); end
    n_checks++; if (m_nack !== 1 || m_ack_at[0] !== 7) begin
      n_err++; $display("FAIL wr_ack: got count %0d at %0d expected 1 at 7", m_nack, m_ack_at[0]); end
    n_checks++; if (m_unstable !== 0) begin n_err++; $display("FAIL wr_dout_stable: got %0d bad cycles expected 0", m_unstable); end
    n_checks++; if (m_rdata[0] !== exp_rd[0] || m_err[0] !== 1'b0) begin
      n_err++; $display("FAIL wr_rdata_kept: got %h/%b expected %h/0", m_rdata[0], m_err[0], exp_rd[0]); end
  endtask

  task automatic test_inta();
    do_txn(0, 1'b1, 1'b0, 1'b1, 20'hABCDE, 8'h99, 1, 8'h11, 8'h08, 1'b0, 1, 0);
    $display("txn inta: ack_at=%0d pulses=%0d gap=%0d rdata=%h", m_ack_at[0], m_pulses, m_min_gap, m_rdata[0]);
    n_checks++; if (m_pulses !== 2 || m_min_gap < 2) begin
      n_err++; $display("FAIL inta_pulses: got %0d pulses gap %0d expected 2 gap>=2", m_pulses, m_min_gap); end
    n_checks++; if (m_rd_lo !== 0 || m_wr_lo !== 0 || m_inta_lo !== 6) begin
      n_err++; $display("FAIL inta_strobes: got %0d/%0d/%0d expected 0/0/6", m_rd_lo, m_wr_lo, m_inta_lo); end
    n_checks++; if (m_nack !== 1 || m_ack_at[0] !== 10) begin
      n_err++; $display("FAIL inta_ack: got count %0d at %0d expected 1 at 10", m_nack, m_ack_at[0]); end
    n_checks++; if (m_rdata[0] !== 8'h08 || m_err[0] !== 1'b0) begin
      n_err++; $display("FAIL inta_vector: got %h/%b expected 08/0", m_rdata[0], m_err[0]); end
    n_checks++; if (m_unstable !== 0) begin n_err++; $display("FAIL inta_addr_iom: got %0d bad cycles expected 0", m_unstable); end
    exp_rd[0] = 8'h08;
  endtask

  task automatic test_timeout();
    // stuck-not-ready read on the TIMEOUT=4 instance
    do_txn(1, 1'b0, 1'b0, 1'b0, 20'h12345, 8'h00, 1000, 8'h3E, 8'h3E, 1'b0, 1, 0);
    $display("txn timeout_read: ack_at=%0d err=%b rdata=%h", m_ack_at[0], m_err[0], m_rdata[0]);
    n_checks++; if (m_nack !== 1 || m_ack_at[0] !== 7) begin
      n_err++; $display("FAIL tmo_ack: got count %0d at %0d expected 1 at 7", m_nack, m_ack_at[0]); end
    n_checks++; if (m_err[0] !== 1'b1 || m_rdata[0] !== 8'hFF) begin
      n_err++; $display("FAIL tmo_result: got %b/%h expected 1/ff", m_err[0], m_rdata[0]); end
    n_checks++; if (m_runs.size() !== 1 || m_rd_lo !== 5) begin
      n_err++; $display("FAIL tmo_strobe: got %0d runs %0d low expected 1 run 5 low", m_runs.size(), m_rd_lo); end
    // ready on the last permitted cycle still completes normally
    do_txn(1, 1'b0, 1'b0, 1'b0, 20'h0F0F0, 8'h00, 3, 8'hC3, 8'hC3, 1'b0, 1, 0);
    $display("txn timeout_edge: ack_at=%0d err=%b rdata=%h", m_ack_at[0], m_err[0], m_rdata[0]);
    n_checks++; if (m_ack_at[0] !== 7 || m_err[0] !== 1'b0 || m_rdata[0] !== 8'hC3) begin
      n_err++; $display("FAIL tmo_edge: got %0d/%b/%h expected 7/0/c3", m_ack_at[0], m_err[0], m_rdata[0]); end
    // INTA aborted on the first pulse ends the sequence at once
    do_txn(1, 1'b0, 1'b0, 1'b1, 20'h00000, 8'h00, 1000, 8'h44, 8'h55, 1'b0, 1, 0);
    $display("txn timeout_inta: ack_at=%0d pulses=%0d err=%b", m_ack_at[0], m_pulses, m_err[0]);
    n_checks++; if (m_pulses !== 1 || m_ack_at[0] !== 7 || m_err[0] !== 1'b1 || m_rdata[0] !== 8'hFF) begin
      n_err++; $display("FAIL tmo_inta: got %0d/%0d/%b/%h expected 1/7/1/ff", m_pulses, m_ack_at[0], m_err[0], m_rdata[0]); end
    exp_rd[1] = 8'hFF;
  endtask

  task automatic test_reset_mid();
    do_txn(0, 1'b1, 1'b0, 1'b0, 20'h2A2A2, 8'hE1, 1000, 8'h00, 8'h00, 1'b0, 0, 5);
    $display("txn reset_mid: busy=%b strobes=%b acks=%0d", m_post_busy, m_post_strobes, m_nack);
    n_checks++; if (m_post_busy !== 1'b0 || m_post_strobes !== 3'b111 || m_post_ack !== 1'b0) begin
      n_err++; $display("FAIL rst_mid_state: got %b/%b/%b expected 0/111/0", m_post_busy, m_post_strobes, m_post_ack); end
    n_checks++; if (m_nack !== 0) begin n_err++; $display("FAIL rst_mid_noack: got %0d expected 0", m_nack); end
    for (int i = 0; i < NI; i++) exp_rd[i] = 8'h00;
    do_txn(0, 1'b0, 1'b0, 1'b0, 20'h00400, 8'h00, 0, 8'h6B, 8'h6B, 1'b0, 1, 0);
    $display("txn after_reset_read: ack_at=%0d rdata=%h", m_ack_at[0], m_rdata[0]);
    n_checks++; if (m_nack !== 1 || m_ack_at[0] !== 4 || m_rdata[0] !== 8'h6B || m_err[0] !== 1'b0) begin
      n_err++; $display("FAIL rst_mid_recover: got %0d at %0d %h/%b expected 1 at 4 6b/0", m_nack, m_ack_at[0], m_rdata[0], m_err[0]); end
    exp_rd[0] = 8'h6B;
  endtask

  task automatic test_back_to_back();
    int n, e1, e2;
    n  = t3_len(WS_T[2], TO_T[2], 0);
    e1 = 3 + n;
    e2 = e1 + 1 + 3 + n;
    do_txn(2, 1'b0, 1'b0, 1'b0, 20'h55555, 8'h00, 0, 8'h1D, 8'h2E, 1'b1, 2, 0);
    $display("txn back_to_back: acks=%0d at %0d,%0d runs=%0d", m_nack, m_ack_at[0], m_ack_at[1], m_runs.size());
    n_checks++; if (m_nack !== 2 || m_ack_at[0] !== e1 || m_ack_at[1] !== e2) begin
      n_err++; $display("FAIL b2b_ack: got %0d at %0d,%0d expected 2 at %0d,%0d", m_nack, m_ack_at[0], m_ack_at[1], e1, e2); end
    n_checks++; if (m_runs.size() !== 2 || m_runs[0] !== n + 1 || m_runs[1] !== n + 1) begin
      n_err++; $display("FAIL b2b_waits: got %0d runs expected 2 runs of %0d", m_runs.size(), n + 1); end
    n_checks++; if (m_rdata[0] !== 8'h1D || m_rdata[1] !== 8'h2E || m_overlap !== 0) begin
      n_err++; $display("FAIL b2b_data: got %h,%h overlap %0d expected 1d,2e overlap 0", m_rdata[0], m_rdata[1], m_overlap); end
    exp_rd[2] = 8'h2E;
  endtask

  task automatic test_random(input int s, input int count);
    logic        we, iom, inta, ok, e_err;
    logic [19:0] addr;
    logic [7:0]  wd, d0, d1, e_rdata;
    int          rd, n, e_ack, e_rdl, e_wrl, e_inl;
    for (int i = 0; i < count; i++) begin
      we = 1'($urandom); iom = 1'($urandom); inta = ($urandom_range(0, 3) == 0);
      addr = 20'($urandom); wd = 8'($urandom); d0 = 8'($urandom); d1 = 8'($urandom);
      rd = $urandom_range(0, (TO_T[s] > 8) ? 5 : TO_T[s] + 1);
      n  = t3_len(WS_T[s], TO_T[s], rd);
      ok = completes(WS_T[s], TO_T[s], rd);
      e_rdl = 0; e_wrl = 0; e_inl = 0;
      if (inta) begin
        e_ack = ok ? 6 + 2 * n : 3 + n;
        e_inl = ok ? 2 * (1 + n) : 1 + n;
      end else begin
        e_ack = 3 + n;
        if (we) e_wrl = 1 + n; else e_rdl = 1 + n;
      end
      e_err   = !ok;
      e_rdata = !ok ? 8'hFF : (inta ? d1 : (!we ? d0 : exp_rd[s]));
      do_txn(s, we, iom, inta, addr, wd, rd, d0, d1, 1'b0, 1, 0);
      $display("txn rand inst=%0d we=%b inta=%b rd=%0d ack_at=%0d err=%b rdata=%h",
               s, we, inta, rd, m_ack_at[0], m_err[0], m_rdata[0]);
      n_checks++; if (m_nack !== 1 || m_ack_at[0] !== e_ack) begin
        n_err++; $display("FAIL rand_ack inst %0d: got %0d at %0d expected 1 at %0d", s, m_nack, m_ack_at[0], e_ack); end
      n_checks++; if (m_err[0] !== e_err || m_rdata[0] !== e_rdata) begin
        n_err++; $display("FAIL rand_result inst %0d: got %b/%h expected %b/%h", s, m_err[0], m_rdata[0], e_err, e_rdata); end
      n_checks++; if (m_rd_lo !== e_rdl || m_wr_lo !== e_wrl || m_inta_lo !== e_inl) begin
        n_err++; $display("FAIL rand_strobes inst %0d: got %0d/%0d/%0d expected %0d/%0d/%0d",
                          s, m_rd_lo, m_wr_lo, m_inta_lo, e_rdl, e_wrl, e_inl); end
      n_checks++; if (m_overlap !== 0 || m_unstable !== 0 || m_busy_after !== 1'b0) begin
        n_err++; $display("FAIL rand_bus inst %0d: got overlap %0d unstable %0d busy %b expected 0 0 0",
                          s, m_overlap, m_unstable, m_busy_after); end
      exp_rd[s] = e_rdata;
    end
  endtask

  initial begin
    n_checks = 0;
    n_err    = 0;
    test_reset();
    test_mem_read();
    test_io_write();
    test_inta();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    for (int s = 0; s < NI; s++) test_random(s, 12);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  // Absolute bound on run time
  initial begin
    #400000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
